board_generator: RTL and testbench
==================================

// Module: board_generator
// PURPOSE
//  Upstream stage of the guess checker. On a start pulse, builds a random board of TILES_LIT
//  distinct lit tiles out of N_TILES using a free-running LFSR. It then flags the board for
//  display for SHOW_CYCLES and holds it stable for the guess-check / guess-count stages.
//  Feeds board[] to the checker; show/show_done drive the display and game FSM.
// PARAMETERS
//  N_TILES      8            number of tiles on the board (2..16)
//  TILES_LIT    3            tiles lit per round (1..N_TILES)
//  SHOW_CYCLES  50_000_000   clk cycles the board is shown (>=1)
//  LFSR_W       16           LFSR width
//  LFSR_TAPS    16'hB400     Galois feedback mask (x^16+x^14+x^13+x^11+1)
//  SEED         16'hACE1     LFSR reset/reload value (non-zero)
// PORTS
//  clk          in   1        clock
//  reset        in   1        reset, synchronous, active-low
//  start        in   1        request a new round (sampled each cycle)
//  board        out  N_TILES  lit-tile mask; one bit per tile
//  board_valid  out  1        board complete and stable (SHOW and HOLD)
//  show         out  1        board must be displayed (SHOW only)
//  show_done    out  1        1-cycle pulse on SHOW->HOLD
//  busy         out  1        high in FILL and SHOW
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, lfsr=SEED, board=0, count=0, timer=0;
//    all outputs 0. Reset mid-round aborts immediately; no show_done is emitted.
//  - LFSR advances every cycle in every state, Galois form:
//    lfsr <= lfsr[0] ? (lfsr>>1)^LFSR_TAPS : lfsr>>1. If lfsr==0, reload SEED.
//  - idx = lfsr[IW-1:0], IW=$clog2(N_TILES). A cycle is a "hit" iff idx<N_TILES and
//    board[idx]==0.
//  - FSM:
//    IDLE: start -> FILL, board<=0, count<=0.
//    FILL: on hit, board[idx]<=1, count<=count+1. When the hit makes count==TILES_LIT:
//          -> SHOW, timer<=SHOW_CYCLES-1. A miss is a no-op. start is ignored.
//    SHOW: show=1. timer decrements each cycle. When timer==0: -> HOLD, show_done=1 for
//          that cycle. start is ignored.
//    HOLD: board stable, board_valid=1, show=0. start -> FILL (board<=0, count<=0);
//          board_valid drops the next cycle.
//  - board_valid=1 in SHOW and HOLD only; board never changes while board_valid=1.
//  - FILL latency is >=TILES_LIT cycles and is data dependent. With the default SEED and
//    parameters it must complete within 64 cycles.
//  - Invariant: popcount(board)==TILES_LIT whenever board_valid=1.
//  - TILES_LIT==N_TILES: FILL ends when all bits are set; board is all ones.
//  - Counter widths: count is $clog2(N_TILES+1) bits; timer is $clog2(SHOW_CYCLES) bits
//    (min 1). No wrap-around is possible.
// CONFIGURATION
//  BOARD_SEED_PORT_EN defined: adds ports
//    seed      in  LFSR_W  external seed (e.g. from switches)
//    seed_load in  1       when 1, lfsr<=(seed==0 ? SEED : seed) in any state, overriding
//                          the normal advance. The FSM is unaffected.
//  Undefined: these ports are absent; lfsr is loaded only from SEED at reset.
// TESTING (bench params: N_TILES=8, TILES_LIT=3, SHOW_CYCLES=10)
//  1. Reset held 3 cycles, then released -> all outputs 0; state IDLE; start=0 holds IDLE.
//  2. start pulse in IDLE -> busy next cycle. board matches the golden LFSR model.
//     board_valid=1 with popcount(board)==3. show is high exactly 10 cycles, then one
//     show_done pulse.
//  3. start asserted during FILL and during SHOW -> ignored; show length stays 10; board
//     unchanged.
//  4. start in HOLD -> board_valid=0 next cycle. New board is valid with popcount 3.
//     1000 rounds: every board has popcount 3; no illegal idx bit is ever set.
//  5. reset=0 mid-SHOW -> next cycle all outputs 0 and no show_done. Rerun with
//     TILES_LIT=8 -> board==8'hFF.
//  6. [BOARD_SEED_PORT_EN] seed=16'h0001, seed_load=1 then start -> board matches the
//     model seeded with 16'h0001. seed=0 -> behaves as SEED.

Source files
------------

// File: rtl/board_generator.sv
// board_generator
//   Builds a random board of TILES_LIT distinct lit tiles (out of N_TILES) on
//   a start request, using a free-running Galois LFSR.
//   It then flags the board for display for SHOW_CYCLES cycles.
//   After that it holds the board stable until the next start.
//
// Ports
//   clk          clock
//   reset        synchronous, active-low reset
//   start        request a new round (ignored while FILL/SHOW)
//   board        lit-tile mask, one bit per tile
//   board_valid  board complete and stable (SHOW and HOLD)
//   show         board must be displayed (SHOW only)
//   show_done    one-cycle pulse, high in the first HOLD cycle
//   busy         high in FILL and SHOW
//
// Optional feature: define BOARD_SEED_PORT_EN to add the seed/seed_load
// ports. These load the LFSR from an external seed, with seed==0 mapped to SEED.
module board_generator #(
    parameter int                N_TILES     = 8,
    parameter int                TILES_LIT   = 3,
    parameter int                SHOW_CYCLES = 50_000_000,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef BOARD_SEED_PORT_EN
    input  logic [LFSR_W-1:0]  seed,
    input  logic               seed_load,
`endif
    output logic [N_TILES-1:0] board,
    output logic               board_valid,
    output logic               show,
    output logic               show_done,
    output logic               busy
);

    localparam int IW = $clog2(N_TILES);
    localparam int CW = $clog2(N_TILES + 1);
    localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [IW:0]   N_LIM      = (IW + 1)'(N_TILES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TILES_LIT - 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SHOW,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [N_TILES-1:0]  board_q, board_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                show_done_q, show_done_d;

    logic [IW-1:0]       idx;
    logic                hit;

    // A tile is taken only if the LFSR index is on the board and not yet lit.
    // This keeps the lit tiles distinct.
    assign idx = lfsr_q[IW-1:0];
    assign hit = ({1'b0, idx} < N_LIM) && !board_q[idx];

    always_comb begin
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end
`ifdef BOARD_SEED_PORT_EN
        if (seed_load) begin
            lfsr_d = (seed == '0) ? SEED : seed;
        end
`endif

        state_d     = state_q;
        board_d     = board_q;
        count_d     = count_q;
        timer_d     = timer_q;
        show_done_d = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (start) begin
                    state_d = FILL;
                    board_d = '0;
                    count_d = '0;
                end
            end
            FILL: begin
                if (hit) begin
                    board_d[idx] = 1'b1;
                    count_d      = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_d = SHOW;
                        timer_d = TIMER_LOAD;
                    end
                end
            end
            SHOW: begin
                if (timer_q == '0) begin
                    state_d     = HOLD;
                    show_done_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            board_q     <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            show_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            board_q     <= board_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            show_done_q <= show_done_d;
        end
    end

    assign board       = board_q;
    assign board_valid = (state_q == SHOW) || (state_q == HOLD);
    assign show        = (state_q == SHOW);
    assign busy        = (state_q == FILL) || (state_q == SHOW);
    assign show_done   = show_done_q;

endmodule

// File: tb/tb_board_generator.sv
module tb_board_generator;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [15:0] seed;
    logic        seed_load;
    logic [7:0]  board, board2;
    logic        board_valid, show, show_done, busy;
    logic        board_valid2, show2, show_done2, busy2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    board_generator #(.N_TILES(8), .TILES_LIT(3), .SHOW_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef BOARD_SEED_PORT_EN
        .seed(seed), .seed_load(seed_load),
`endif
        .board(board), .board_valid(board_valid), .show(show),
        .show_done(show_done), .busy(busy)
    );

    board_generator #(.N_TILES(8), .TILES_LIT(8), .SHOW_CYCLES(10)) dut_all (
        .clk(clk), .reset(reset), .start(start2),
`ifdef BOARD_SEED_PORT_EN
        .seed(16'h0000), .seed_load(1'b0),
`endif
        .board(board2), .board_valid(board_valid2), .show(show2),
        .show_done(show_done2), .busy(busy2)
    );

    // Reference LFSR sequence, per the Galois rule
    function automatic logic [15:0] nxt(input logic [15:0] l);
        if (l == 16'h0) return SEED;
        return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    endfunction

    logic [15:0] m1, m2;
    always @(posedge clk) begin
        if (!reset) begin
            m1 <= SEED;
            m2 <= SEED;
        end else begin
            m2 <= nxt(m2);
`ifdef BOARD_SEED_PORT_EN
            if (seed_load) m1 <= (seed == 16'h0) ? SEED : seed;
            else           m1 <= nxt(m1);
`else
            m1 <= nxt(m1);
`endif
        end
    end

    // Walk the LFSR sequence from l0 and light distinct tiles until tl are lit.
    // len is the number of sequence values consumed.
    function automatic void predict(input logic [15:0] l0, input int tl,
                                    output logic [7:0] b, output int len);
        logic [15:0] l;
        int          c;
        logic [2:0]  k;
        b   = '0;
        len = 0;
        c   = 0;
        l   = l0;
        for (int i = 0; i < 10000; i++) begin
            len++;
            k = l[2:0];
            if (!b[k]) begin
                b[k] = 1'b1;
                c++;
                if (c == tl) break;
            end
            l = nxt(l);
        end
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; start2 = 1'b0; seed = '0; seed_load = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({board, board_valid, show, show_done, busy} !== 12'h0)
                $display("FAIL reset_outputs: got %h required 0",
                         {board, board_valid, show, show_done, busy});
            else n_pass++;
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({board, board_valid, show, show_done, busy} !== 12'h0)
                $display("FAIL idle_hold: got %h required 0",
                         {board, board_valid, show, show_done, busy});
            else n_pass++;
        end
    endtask

    // One full round starting from IDLE or HOLD; poke asserts start in FILL and SHOW.
    task automatic run_round(input bit poke);
        logic [7:0] pb;
        int         plen, cyc, sl;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        predict(m1, 3, pb, plen);
        n_checks++;
        if (busy !== 1'b1 || board_valid !== 1'b0 || show !== 1'b0)
            $display("FAIL fill_entry: busy=%b valid=%b show=%b required 1/0/0",
                     busy, board_valid, show);
        else n_pass++;
        cyc = 1;
        while (!board_valid && cyc < 100) begin
            if (poke && cyc == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        n_checks++;
        if (cyc !== plen + 1) $display("FAIL fill_len: got %0d required %0d", cyc - 1, plen);
        else n_pass++;
        n_checks++;
        if (board !== pb) $display("FAIL board: got %h required %h", board, pb);
        else n_pass++;
        n_checks++;
        if ($countones(board) != 3 || show !== 1'b1)
            $display("FAIL popcount_show: pop=%0d show=%b required 3/1", $countones(board), show);
        else n_pass++;
        sl = 0;
        while (show && sl < 100) begin
            sl++;
            if (poke && sl == 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (sl != 10) $display("FAIL show_len: got %0d required 10", sl);
        else n_pass++;
        n_checks++;
        if (show_done !== 1'b1 || board_valid !== 1'b1 || busy !== 1'b0 || board !== pb)
            $display("FAIL show_done: done=%b valid=%b busy=%b board=%h required 1/1/0/%h",
                     show_done, board_valid, busy, board, pb);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (show_done !== 1'b0 || board_valid !== 1'b1 || board !== pb)
            $display("FAIL hold: done=%b valid=%b board=%h required 0/1/%h",
                     show_done, board_valid, board, pb);
        else n_pass++;
    endtask

    task automatic test_rounds();
        run_round(1'b0);
        run_round(1'b1);
        for (int r = 0; r < 1000; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_round(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_show();
        int w;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        w = 0;
        while (!show && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({board, board_valid, show, show_done, busy} !== 12'h0)
            $display("FAIL reset_mid_show: got %h required 0",
                     {board, board_valid, show, show_done, busy});
        else n_pass++;
        reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if (show_done !== 1'b0 || busy !== 1'b0 || board_valid !== 1'b0)
                $display("FAIL after_abort: done=%b busy=%b valid=%b required 0/0/0",
                         show_done, busy, board_valid);
            else n_pass++;
        end
    endtask

    task automatic test_all_lit();
        logic [7:0] pb;
        int         plen, cyc;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        predict(m2, 8, pb, plen);
        cyc = 1;
        while (!board_valid2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (board2 !== 8'hFF || pb !== 8'hFF)
            $display("FAIL all_lit: got %h required ff", board2);
        else n_pass++;
        n_checks++;
        if (cyc !== plen + 1) $display("FAIL all_lit_len: got %0d required %0d", cyc - 1, plen);
        else n_pass++;
    endtask

`ifdef BOARD_SEED_PORT_EN
    task automatic test_seed_port();
        logic [15:0] expect_l;
        @(negedge clk) begin seed = 16'h0001; seed_load = 1'b1; end
        @(negedge clk) seed_load = 1'b0;
        expect_l = 16'h0001;
        n_checks++;
        if (m1 !== expect_l) $display("FAIL seed_model: got %h required 0001", m1);
        else n_pass++;
        run_round(1'b0);
        @(negedge clk) begin seed = 16'h0000; seed_load = 1'b1; end
        @(negedge clk) seed_load = 1'b0;
        run_round(1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_rounds();
        test_reset_mid_show();
        test_all_lit();
`ifdef BOARD_SEED_PORT_EN
        test_seed_port();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
